// File: rtl/sr_loader_pkg.sv
// Shared definitions for the shift-register target loader: sequence states,
// target select encoding and the default word width.
package sr_loader_pkg;

   localparam int DEF_WORD_WIDTH = 32;

   // Target select encoding carried on load_select
   localparam logic SEL_DIVIDER = 1'b0;
   localparam logic SEL_ROW     = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RESET = 3'd1,
      LEAD  = 3'd2,
      SHIFT = 3'd3,
      TRAIL = 3'd4,
      DONE  = 3'd5
   } state_e;

   // States in which the selected register's shift enable is held high
   function automatic logic drives_enable(input state_e s);
      return (s == LEAD) || (s == SHIFT) || (s == TRAIL);
   endfunction

endpackage

// File: rtl/sr_clock_gen.sv
// Serial clock generator: a half-period down-counter that flips the
// registered sr_data_clock each time it expires, while run is high.
// With run low the clock is parked low and the counter is preloaded so the
// first phase after run rises is a full low half period.
module sr_clock_gen
   import sr_loader_pkg::*;
#(
   parameter int HALF_PERIOD = 4
) (
   input  logic sys_clock,
   input  logic sys_reset,
   input  logic run,
   output logic phase_tick,
   output logic sr_data_clock
);

   localparam logic [7:0] RELOAD   = 8'(HALF_PERIOD - 1);
   localparam logic [7:0] CNT_ZERO = 8'd0;
   localparam logic [7:0] CNT_ONE  = 8'd1;

   logic [7:0] half_cnt_r;
   logic       data_clock_r;

   // A phase ends on the last cycle of the current half period
   assign phase_tick    = run && (half_cnt_r == CNT_ZERO);
   assign sr_data_clock = data_clock_r;

   // Half-period counter and serial clock register
   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         half_cnt_r   <= CNT_ZERO;
         data_clock_r <= 1'b0;
      end else if (!run) begin
         half_cnt_r   <= RELOAD;
         data_clock_r <= 1'b0;
      end else if (half_cnt_r == CNT_ZERO) begin
         half_cnt_r   <= RELOAD;
         data_clock_r <= ~data_clock_r;
      end else begin
         half_cnt_r   <= half_cnt_r - CNT_ONE;
         data_clock_r <= data_clock_r;
      end
   end

endmodule

// File: rtl/sr_target_loader.sv
// Loads a parallel word into one of the divider's two serial target
// registers: reset pulse, guarded enable window, MSB-first shift with a
// generated serial clock, then a one-cycle done pulse. All sequence outputs
// are registered from the next-state decode so they line up with the state.
module sr_target_loader
   import sr_loader_pkg::*;
#(
   parameter int HALF_PERIOD  = 4,
   parameter int RESET_CYCLES = 2,
   parameter int GUARD_CYCLES = 2,
   parameter int WORD_WIDTH   = DEF_WORD_WIDTH
) (
   input  logic                  sys_clock,
   input  logic                  sys_reset,
   input  logic                  load_valid,
   input  logic                  load_select,
   input  logic                  load_clear_only,
   input  logic [WORD_WIDTH-1:0] load_word,
   output logic                  load_ready,
   output logic                  load_done,
   output logic                  sr_data,
   output logic                  sr_data_clock,
   output logic                  sr_div_data_enable,
   output logic                  sr_div_data_reset,
   output logic                  sr_row_data_enable,
   output logic                  sr_row_data_reset
);

   localparam int IDX_W = $clog2(WORD_WIDTH);
   localparam int CNT_W = 8;

   localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WORD_WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

   state_e                state_r, state_s;
   logic [CNT_W-1:0]      cnt_r, cnt_s;
   logic [IDX_W-1:0]      idx_r, idx_s;
   logic [WORD_WIDTH-1:0] word_r, word_s;
   logic                  sel_r, sel_s;
   logic                  clear_r, clear_s;
   logic                  data_r, data_s, data_out_s;
   logic                  ready_r, ready_s;
   logic                  done_r, done_s;
   logic                  div_en_r, div_en_s, div_rst_r, div_rst_s;
   logic                  row_en_r, row_en_s, row_rst_r, row_rst_s;
   logic                  run_s, phase_tick_s, data_clock_s;

   assign run_s = (state_r == SHIFT);

   sr_clock_gen #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_clock_gen (
      .sys_clock     (sys_clock),
      .sys_reset     (sys_reset),
      .run           (run_s),
      .phase_tick    (phase_tick_s),
      .sr_data_clock (data_clock_s)
   );

   // Next-state, capture and output decode for the load sequence
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      word_s  = word_r;
      sel_s   = sel_r;
      clear_s = clear_r;
      data_s  = data_r;
      case (state_r)
         IDLE: begin
            if (load_valid) begin
               word_s  = load_word;
               sel_s   = load_select;
               clear_s = load_clear_only;
               cnt_s   = RESET_LOAD;
               state_s = RESET;
            end else begin
               state_s = IDLE;
            end
         end
         RESET: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_s = cnt_r - CNT_ONE;
            end else if (clear_r) begin
               state_s = DONE;
            end else begin
               state_s = LEAD;
               cnt_s   = GUARD_LOAD;
               idx_s   = IDX_LAST;
               data_s  = word_r[WORD_WIDTH-1];
            end
         end
         LEAD: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_s = cnt_r - CNT_ONE;
            end else begin
               state_s = SHIFT;
            end
         end
         SHIFT: begin
            // Bits advance only as the serial clock falls, keeping data
            // stable around every rising edge.
            if (phase_tick_s && data_clock_s) begin
               if (idx_r == IDX_ZERO) begin
                  state_s = TRAIL;
                  cnt_s   = GUARD_LOAD;
               end else begin
                  idx_s  = idx_r - IDX_ONE;
                  data_s = word_r[idx_r - IDX_ONE];
               end
            end else begin
               state_s = SHIFT;
            end
         end
         TRAIL: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_s = cnt_r - CNT_ONE;
            end else begin
               state_s = DONE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      ready_s    = (state_s == IDLE);
      done_s     = (state_s == DONE);
      data_out_s = drives_enable(state_s) ? data_s : 1'b0;
      div_en_s   = drives_enable(state_s) && (sel_s == SEL_DIVIDER);
      div_rst_s  = (state_s == RESET) && (sel_s == SEL_DIVIDER);
      row_en_s   = drives_enable(state_s) && (sel_s == SEL_ROW);
      row_rst_s  = (state_s == RESET) && (sel_s == SEL_ROW);
   end

   // State, counters, captured request and registered outputs
   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         idx_r     <= IDX_ZERO;
         word_r    <= '0;
         sel_r     <= 1'b0;
         clear_r   <= 1'b0;
         data_r    <= 1'b0;
         ready_r   <= 1'b1;
         done_r    <= 1'b0;
         div_en_r  <= 1'b0;
         div_rst_r <= 1'b0;
         row_en_r  <= 1'b0;
         row_rst_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         idx_r     <= idx_s;
         word_r    <= word_s;
         sel_r     <= sel_s;
         clear_r   <= clear_s;
         data_r    <= data_out_s;
         ready_r   <= ready_s;
         done_r    <= done_s;
         div_en_r  <= div_en_s;
         div_rst_r <= div_rst_s;
         row_en_r  <= row_en_s;
         row_rst_r <= row_rst_s;
      end
   end

   assign load_ready         = ready_r;
   assign load_done          = done_r;
   assign sr_data            = data_r;
   assign sr_data_clock      = data_clock_s;
   assign sr_div_data_enable = div_en_r;
   assign sr_div_data_reset  = div_rst_r;
   assign sr_row_data_enable = row_en_r;
   assign sr_row_data_reset  = row_rst_r;

endmodule

// File: tb/tb_sr_target_loader.sv
// Bench for sr_target_loader: two instances (HALF_PERIOD 4 and 1) share one
// stimulus stream. A timeline model per instance predicts every output from
// the cycle number since acceptance; serial receivers rebuild the shifted
// registers, and directed steps pin latencies and captured words literally.
module tb_sr_target_loader;
   import sr_loader_pkg::*;

   localparam int W  = 32;
   localparam int RC = 2;
   localparam int GC = 2;

   logic        sys_clock = 1'b0;
   logic        sys_reset, load_valid, load_select, load_clear_only;
   logic [31:0] load_word;
   logic        ready [2], done [2], sdata [2], sclk [2];
   logic        den [2], drst [2], ren [2], rrst [2];

   int checks = 0;
   int errors = 0;

   always #5 sys_clock = ~sys_clock;

   sr_target_loader #(.HALF_PERIOD(4)) dut0 (
      .sys_clock(sys_clock), .sys_reset(sys_reset), .load_valid(load_valid),
      .load_select(load_select), .load_clear_only(load_clear_only), .load_word(load_word),
      .load_ready(ready[0]), .load_done(done[0]), .sr_data(sdata[0]), .sr_data_clock(sclk[0]),
      .sr_div_data_enable(den[0]), .sr_div_data_reset(drst[0]),
      .sr_row_data_enable(ren[0]), .sr_row_data_reset(rrst[0]));

   sr_target_loader #(.HALF_PERIOD(1)) dut1 (
      .sys_clock(sys_clock), .sys_reset(sys_reset), .load_valid(load_valid),
      .load_select(load_select), .load_clear_only(load_clear_only), .load_word(load_word),
      .load_ready(ready[1]), .load_done(done[1]), .sr_data(sdata[1]), .sr_data_clock(sclk[1]),
      .sr_div_data_enable(den[1]), .sr_div_data_reset(drst[1]),
      .sr_row_data_enable(ren[1]), .sr_row_data_reset(rrst[1]));

   function automatic int hp_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   // Cycle (1 = first cycle after the accept edge) in which load_done is high
   function automatic int done_cycle(input logic clr, input int hp);
      return clr ? (RC + 1) : (RC + GC + 2 * hp * W + GC + 1);
   endfunction

   // Expected {ready, done, data, clock, div_en, div_rst, row_en, row_rst}
   function automatic logic [7:0] expect_out(input logic busy, input int t, input logic sel,
                                             input logic clr, input logic [31:0] word, input int hp);
      logic rdy, dn, d, c, en, rs;
      int   s, shift0, trail0;
      rdy = 1'b0; dn = 1'b0; d = 1'b0; c = 1'b0; en = 1'b0; rs = 1'b0;
      shift0 = RC + GC + 1;
      trail0 = shift0 + 2 * hp * W;
      if (!busy) rdy = 1'b1;
      else if (t <= RC) rs = 1'b1;
      else if (t == done_cycle(clr, hp)) dn = 1'b1;
      else if (t < shift0) begin en = 1'b1; d = word[W-1]; end
      else if (t < trail0) begin
         s  = t - shift0;
         en = 1'b1;
         d  = word[W - 1 - s / (2 * hp)];
         c  = (s % (2 * hp)) >= hp;
      end else begin en = 1'b1; d = word[0]; end
      return {rdy, dn, d, c, sel ? 1'b0 : en, sel ? 1'b0 : rs, sel ? en : 1'b0, sel ? rs : 1'b0};
   endfunction

   // Timeline model state
   logic        m_live = 1'b0;
   logic        m_busy [2] = '{1'b0, 1'b0};
   int          m_t    [2] = '{0, 0};
   logic        m_sel  [2], m_clr [2];
   logic [31:0] m_word [2];

   // Model: acceptance, cycle counting and return to idle
   always @(posedge sys_clock) begin
      if (sys_reset) begin
         m_live <= 1'b1;
         for (int i = 0; i < 2; i++) m_busy[i] <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_busy[i]) begin
               if (m_t[i] == done_cycle(m_clr[i], hp_of(i))) m_busy[i] <= 1'b0;
               else m_t[i] <= m_t[i] + 1;
            end else if (load_valid) begin
               m_busy[i] <= 1'b1;
               m_t[i]    <= 1;
               m_sel[i]  <= load_select;
               m_clr[i]  <= load_clear_only;
               m_word[i] <= load_word;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge sys_clock) begin
      if (m_live) begin
         for (int i = 0; i < 2; i++) begin
            logic [7:0] act, exp_v;
            act   = {ready[i], done[i], sdata[i], sclk[i], den[i], drst[i], ren[i], rrst[i]};
            exp_v = expect_out(m_busy[i], m_t[i], m_sel[i], m_clr[i], m_word[i], hp_of(i));
            checks++;
            if (act !== exp_v) begin
               errors++;
               if (errors < 30)
                  $display("FAIL cycle_outputs dut%0d t=%0d got %b expected %b", i, m_t[i], act, exp_v);
            end
         end
      end
   end

   // Serial receivers, rising-edge counts, acceptance counts and latency
   logic [31:0] div_sr [2] = '{32'd0, 32'd0};
   logic [31:0] row_sr [2] = '{32'd0, 32'd0};
   int          edges  [2] = '{0, 0};
   int          acc    [2] = '{0, 0};
   int          lat    [2] = '{0, 0};
   int          lat_cnt[2] = '{0, 0};
   logic        sclk_prev [2] = '{1'b0, 1'b0};
   logic        rdy_prev  [2] = '{1'b0, 1'b0};

   always @(negedge sys_clock) begin
      for (int i = 0; i < 2; i++) begin
         if (drst[i] === 1'b1) div_sr[i] = 32'd0;
         if (rrst[i] === 1'b1) row_sr[i] = 32'd0;
         if (drst[i] === 1'b1 || rrst[i] === 1'b1) edges[i] = 0;
         if (sclk[i] === 1'b1 && sclk_prev[i] === 1'b0) begin
            edges[i]++;
            if (den[i] === 1'b1) div_sr[i] = {div_sr[i][30:0], sdata[i]};
            if (ren[i] === 1'b1) row_sr[i] = {row_sr[i][30:0], sdata[i]};
         end
         sclk_prev[i] = sclk[i];
         if (rdy_prev[i] === 1'b1 && ready[i] === 1'b0) begin
            acc[i]++;
            lat_cnt[i] = 1;
         end else begin
            lat_cnt[i]++;
         end
         if (done[i] === 1'b1) lat[i] = lat_cnt[i];
         rdy_prev[i] = ready[i];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin @(posedge sys_clock); #1; n++; end
      while (!(ready[0] === 1'b1 && ready[1] === 1'b1) && n < 700);
      checks++;
      if (!(ready[0] === 1'b1 && ready[1] === 1'b1)) begin
         errors++;
         $display("FAIL timeout_idle waited %0d cycles", n);
      end
   endtask

   task automatic do_load(input logic sel, input logic clr, input logic [31:0] w);
      wait_idle();
      load_valid = 1'b1; load_select = sel; load_clear_only = clr; load_word = w;
      @(posedge sys_clock); #1;
      load_valid = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int n;
      n = 0;
      do begin @(negedge sys_clock); #1; n++; end
      while (done[i] !== 1'b1 && n < 400);
      checks++;
      if (done[i] !== 1'b1) begin
         errors++;
         $display("FAIL timeout_done dut%0d after %0d cycles", i, n);
      end
   endtask

   int acc_before;

   initial begin
      sys_reset = 1'b1; load_valid = 1'b0; load_select = 1'b0;
      load_clear_only = 1'b0; load_word = 32'd0;
      repeat (3) @(posedge sys_clock);
      #1 sys_reset = 1'b0;

      // Idle after reset
      repeat (20) @(posedge sys_clock);
      @(negedge sys_clock); #1;
      check("idle_ready0", ready[0], 32'd1);
      check("idle_ready1", ready[1], 32'd1);
      check("idle_sr_outputs0", {sdata[0], sclk[0], den[0], drst[0], ren[0], rrst[0]}, 32'd0);

      // Full load to the divider register
      do_load(SEL_DIVIDER, 1'b0, 32'h8000_0005);
      wait_done(0);
      check("div_latency_hp4", lat[0], 32'd263);
      check("div_latency_hp1", lat[1], 32'd71);
      check("div_word_hp4", div_sr[0], 32'h8000_0005);
      check("div_word_hp1", div_sr[1], 32'h8000_0005);
      check("div_edges_hp4", edges[0], 32'd32);
      check("div_edges_hp1", edges[1], 32'd32);

      // Full load to the row register
      do_load(SEL_ROW, 1'b0, 32'h0000_1234);
      wait_done(0);
      check("row_latency_hp1", lat[1], 32'd71);
      check("row_latency_hp4", lat[0], 32'd263);
      check("row_word_hp1", row_sr[1], 32'h0000_1234);
      check("row_word_hp4", row_sr[0], 32'h0000_1234);
      check("div_untouched", div_sr[0], 32'h8000_0005);

      // Clear-only on the divider register
      do_load(SEL_DIVIDER, 1'b1, 32'hDEAD_BEEF);
      wait_done(0);
      check("clear_latency_hp4", lat[0], 32'd3);
      check("clear_latency_hp1", lat[1], 32'd3);
      check("clear_no_edges", edges[0], 32'd0);
      check("clear_div_zero", div_sr[0], 32'd0);

      // load_valid held high: one load at a time
      wait_idle();
      acc_before = acc[0];
      load_valid = 1'b1; load_select = SEL_DIVIDER; load_clear_only = 1'b0;
      load_word = 32'hA5A5_0F0F;
      wait_done(0);
      check("held_valid_single", acc[0] - acc_before, 32'd1);
      @(negedge sys_clock); #1;
      check("held_valid_ready_back", ready[0], 32'd1);
      @(negedge sys_clock); #1;
      check("held_valid_second", acc[0] - acc_before, 32'd2);
      load_valid = 1'b0;
      wait_done(0);
      check("held_valid_word", div_sr[0], 32'hA5A5_0F0F);

      // Reset during bit 10 of the shift, then a fresh all-ones load
      do_load(SEL_DIVIDER, 1'b0, 32'h1357_9BDF);
      repeat (85) @(posedge sys_clock);
      #1;
      check("edges_before_abort", edges[0], 32'd10);
      sys_reset = 1'b1;
      @(posedge sys_clock); #1;
      sys_reset = 1'b0;
      @(negedge sys_clock); #1;
      check("abort_ready", ready[0], 32'd1);
      check("abort_outputs", {done[0], sdata[0], sclk[0], den[0], drst[0], ren[0], rrst[0]}, 32'd0);
      do_load(SEL_DIVIDER, 1'b0, 32'hFFFF_FFFF);
      wait_done(0);
      check("reload_word", div_sr[0], 32'hFFFF_FFFF);
      check("reload_latency", lat[0], 32'd263);

      // Randomised traffic, including occasional resets
      for (int k = 0; k < 3000; k++) begin
         @(posedge sys_clock); #1;
         load_valid      = ($urandom_range(0, 3) == 0);
         load_select     = 1'($urandom_range(0, 1));
         load_clear_only = ($urandom_range(0, 3) == 0);
         load_word       = $urandom;
         sys_reset       = ($urandom_range(0, 599) == 0);
      end
      @(posedge sys_clock); #1;
      load_valid = 1'b0; sys_reset = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
